// File: rtl/fetch_sequencer.sv
// Instruction sequencer: owns the PC, start/load/halt flow, branch target
// selection, data-memory wait stalls and the committed-instruction counter.
module fetch_sequencer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16,
  parameter logic [INSTR_W-1:0] HALT_WORD = {INSTR_W{1'b1}}
) (
  input  logic               CLK,
  input  logic               Reset_N,
  input  logic               Start,
  input  logic [PC_W-1:0]    Start_Addr,
  input  logic [INSTR_W-1:0] InstrIn,
  input  logic               Branch,
  input  logic               Zero,
  input  logic               BrMode,
  input  logic [PC_W-1:0]    BrTarget,
  input  logic               MemAccess,
  input  logic               MemReady,
  output logic [PC_W-1:0]    PC,
  output logic               ExecEn,
  output logic               Busy,
  output logic               Done,
  output logic [CNT_W-1:0]   InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_WAIT = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              is_halt;
  logic              stall;
  logic              active;
  logic              exec_en;

  assign is_halt = (InstrIn == HALT_WORD);
  assign stall   = MemAccess & ~MemReady;
  assign active  = (state_q == S_RUN) || (state_q == S_WAIT);

  // State register
  always_ff @(posedge CLK) begin
    if (!Reset_N) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; Start overrides every state and aborts a held instruction
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (Start) begin
      state_d = S_LOAD;
      pc_d    = Start_Addr;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_LOAD: state_d = S_RUN;
        S_RUN, S_WAIT: begin
          if (is_halt) begin
            state_d = S_HALT;
          end else if (stall) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_RUN;
            if (Branch && Zero) pc_d = BrMode ? BrTarget : (pc_q + BrTarget);
            else                pc_d = pc_q + PC_ONE;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: combinational commit strobe plus next values of status flags
  always_comb begin
    exec_en = active && !Start && !is_halt && !stall;
    busy_d  = (state_d == S_RUN) || (state_d == S_WAIT);
    done_d  = (state_d == S_HALT);
  end

  assign PC         = pc_q;
  assign ExecEn     = exec_en;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios then random traffic,
// each cycle checked against a phase-level reference model.
module tb_fetch_sequencer;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 4;
  localparam logic [INSTR_W-1:0] HALT = {INSTR_W{1'b1}};
  localparam int REC_W = 5 + CNT_W + PC_W;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_HALT = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               start;
  logic [PC_W-1:0]    start_addr;
  logic [INSTR_W-1:0] instr_in;
  logic               branch, zero, br_mode;
  logic [PC_W-1:0]    br_target;
  logic               mem_access, mem_ready;
  logic [PC_W-1:0]    pc;
  logic               exec_en, busy, done;
  logic [CNT_W-1:0]   instr_count;

  fetch_sequencer #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W), .HALT_WORD(HALT)
  ) dut (
    .CLK(clk), .Reset_N(rst_n), .Start(start), .Start_Addr(start_addr),
    .InstrIn(instr_in), .Branch(branch), .Zero(zero), .BrMode(br_mode),
    .BrTarget(br_target), .MemAccess(mem_access), .MemReady(mem_ready),
    .PC(pc), .ExecEn(exec_en), .Busy(busy), .Done(done),
    .InstrCount(instr_count)
  );

  // scoreboard: {valid, check_exec, exec, busy, done, count, pc}
  logic [REC_W-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // reference model state
  int               ph;
  logic [PC_W-1:0]  m_pc;
  logic [CNT_W-1:0] m_cnt;
  bit               rec_valid;

  // driver: caller sets inputs just after a rising edge; tick records the
  // expected outputs for this cycle, advances the model, and waits one edge
  task automatic tick();
    bit halt_i, stall_i, ex;
    halt_i  = (instr_in == HALT);
    stall_i = mem_access && !mem_ready;
    ex      = (ph == P_RUN) && !start && !halt_i && !stall_i;
    exp_q.push_back({rec_valid, rst_n, ex, (ph == P_RUN), (ph == P_HALT), m_cnt, m_pc});
    if (!rst_n) begin
      ph = P_IDLE; m_pc = '0; m_cnt = '0;
    end else if (start) begin
      ph = P_LOAD; m_pc = start_addr; m_cnt = '0;
    end else if (ph == P_LOAD) begin
      ph = P_RUN;
    end else if (ph == P_RUN) begin
      if (halt_i) ph = P_HALT;
      else if (!stall_i) begin
        if (branch && zero) m_pc = br_mode ? br_target : m_pc + br_target;
        else                m_pc = m_pc + 1'b1;
        if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    start = 0; start_addr = '0; instr_in = '0; branch = 0; zero = 0;
    br_mode = 0; br_target = '0; mem_access = 0; mem_ready = 0;
  endtask

  task automatic go(input logic [PC_W-1:0] addr);
    quiet();
    start = 1; start_addr = addr; tick();
    start = 0; tick();
  endtask

  // monitor: compares DUT outputs against the oldest expectation mid-cycle
  always @(negedge clk) begin
    logic [REC_W-1:0] r;
    logic [PC_W-1:0]  e_pc;
    logic [CNT_W-1:0] e_cnt;
    bit ok;
    cyc++;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      e_pc  = r[PC_W-1:0];
      e_cnt = r[PC_W +: CNT_W];
      if (r[REC_W-1]) begin
        ok = (pc === e_pc) && (instr_count === e_cnt) &&
             (done === r[PC_W+CNT_W]) && (busy === r[PC_W+CNT_W+1]) &&
             (!r[PC_W+CNT_W+3] || exec_en === r[PC_W+CNT_W+2]);
        checks++;
        if (ok) passes++;
        else $display("FAIL cycle %0d outputs: got pc=%h cnt=%h exec=%b busy=%b done=%b, want pc=%h cnt=%h exec=%b busy=%b done=%b",
                      cyc, pc, instr_count, exec_en, busy, done,
                      e_pc, e_cnt, r[PC_W+CNT_W+2], r[PC_W+CNT_W+1], r[PC_W+CNT_W]);
      end
    end
  end

  initial begin
    quiet();
    rst_n = 0;
    rec_valid = 0;
    ph = P_IDLE; m_pc = '0; m_cnt = '0;
    @(posedge clk); #1;
    tick();                       // power-up: outputs unknown, not checked
    rec_valid = 1;
    tick();                       // reset state
    start = 1; start_addr = 8'h77; tick();  // reset beats start
    rst_n = 1; quiet(); tick(); tick();

    // straight-line program 10..14 then halt at 15
    go(8'h10);
    repeat (5) tick();
    instr_in = HALT; repeat (3) tick();

    // relative branch taken and not taken from 20
    go(8'h20);
    branch = 1; zero = 1; br_mode = 0; br_target = 8'hFC; tick();
    quiet(); tick();
    go(8'h20);
    branch = 1; zero = 0; br_mode = 0; br_target = 8'hFC; tick();
    quiet(); tick();

    // absolute branch and wrap at FF
    go(8'hFF);
    branch = 1; zero = 1; br_mode = 1; br_target = 8'h05; tick();
    quiet(); tick();
    go(8'hFF);
    tick(); tick();

    // three-cycle memory stall then one commit
    go(8'h30);
    mem_access = 1; mem_ready = 0; repeat (3) tick();
    mem_ready = 1; tick();
    quiet(); tick();

    // start during WAIT aborts the held instruction
    go(8'h40);
    tick(); tick();
    mem_access = 1; mem_ready = 0; tick(); tick();
    start = 1; start_addr = 8'h50; tick();
    quiet(); tick(); tick(); tick();

    // counter saturation, then reset mid-run
    go(8'h00);
    repeat (20) tick();
    rst_n = 0; tick();
    rst_n = 1; tick(); tick();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst_n      = ($urandom_range(0, 63) != 0);
      start      = ($urandom_range(0, 15) == 0);
      start_addr = PC_W'($urandom());
      instr_in   = ($urandom_range(0, 15) == 0) ? HALT : INSTR_W'($urandom_range(0, 510));
      branch     = $urandom_range(0, 1);
      zero       = $urandom_range(0, 1);
      br_mode    = $urandom_range(0, 1);
      br_target  = PC_W'($urandom());
      mem_access = ($urandom_range(0, 3) == 0);
      mem_ready  = $urandom_range(0, 1);
      tick();
    end
    quiet(); rst_n = 1; tick();

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Parametrised instruction-sequencing block for the Beeth9 core family. It owns the program counter, the start/load/halt control flow, branch target selection (relative or absolute), data-memory wait stalls and the dynamic instruction counter. It sits between the instruction ROM and the decode/execute datapath, replacing the fixed 8-bit single-mode fetch logic.

## Interface
Parameters:
- PC_W, 8, program counter width; instruction ROM depth is 2^PC_W.
- INSTR_W, 9, instruction word width.
- CNT_W, 16, instruction counter width.
- HALT_WORD, {INSTR_W{1'b1}}, instruction encoding that halts the core.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset_N  in  1  synchronous reset, active-low.
- Start  in  1  level; while high, the core is held and the PC is loaded.
- Start_Addr  in  PC_W  PC load value used while Start is high.
- InstrIn  in  INSTR_W  instruction at PC, combinational from the ROM.
- Branch  in  1  current instruction is a conditional branch (from Control).
- Zero  in  1  ALU zero flag for the current instruction.
- BrMode  in  1  0 = relative (PC + BrTarget, two's complement), 1 = absolute (BrTarget).
- BrTarget  in  PC_W  branch offset or absolute target.
- MemAccess  in  1  current instruction reads or writes data memory.
- MemReady  in  1  data memory completes the access this cycle.
- PC  out  PC_W  registered program counter.
- ExecEn  out  1  combinational; current instruction commits on this edge. The datapath gates register-file and memory writes with it.
- Busy  out  1  registered; high in RUN or WAIT.
- Done  out  1  registered; high in HALT.
- InstrCount  out  CNT_W  committed-instruction count.

## Operation
- States: IDLE, LOAD, RUN, WAIT, HALT.
- Priority on every edge: Reset_N low, then Start high, then normal transitions.
- Reset (Reset_N = 0 at an edge):
  - State goes to IDLE.
  - PC = 0, InstrCount = 0, Busy = 0, Done = 0. ExecEn is 0 while in IDLE.
- Start high in any state:
  - Next state is LOAD.
  - PC <= Start_Addr and InstrCount <= 0.
  - ExecEn is 0, which aborts any in-flight instruction, including one held in WAIT.
- LOAD with Start low: next state is RUN. PC is held.
- IDLE with Start low: stays in IDLE.
- RUN and WAIT, with Start low:
  - halt = (InstrIn == HALT_WORD). A halt instruction goes to HALT, is not counted, and leaves PC unchanged.
  - Otherwise, if MemAccess is high and MemReady is low: go to or stay in WAIT, with ExecEn = 0 and PC held.
  - Otherwise, commit: ExecEn = 1, then return to or stay in RUN.
- On commit:
  - taken = Branch & Zero.
  - PC <= taken ? (BrMode ? BrTarget : PC + BrTarget) : PC + 1.
  - All PC arithmetic is modulo 2^PC_W, so PC wraps from all-ones to 0 with no error.
  - InstrCount <= InstrCount + 1, saturating at all-ones (holds at the maximum).
- HALT: held until Start or reset. PC and InstrCount are frozen. Done = 1.
- MemReady is ignored when MemAccess is low. MemReady arriving in the same RUN cycle as the request gives a zero-wait commit.

## Timing
- One instruction per cycle in RUN when there are no stalls.
- The PC update is visible one cycle after the commit edge.
- ExecEn is valid in the same cycle as InstrIn.
- Start-to-first-commit latency:
  - Start is sampled high at edge N, so PC = Start_Addr after N.
  - Start is sampled low at edge N+1, so the state is RUN after N+1.
  - The first commit occurs at edge N+2.
- A memory stall adds exactly k cycles for k cycles of MemReady low.
- Busy and Done change on the edge that enters or leaves their states.
- Reset asserted in the same cycle as Start: reset wins, so state is IDLE and PC = 0.

## Test plan
- Reset then Start = 1 for 1 cycle with Start_Addr = 8'h10, 5 non-branch, non-memory instructions, then HALT_WORD at 8'h15: PC steps 10..15 and Done rises. InstrCount = 5, and ExecEn pulses exactly 5 times.
- Relative branch at PC = 8'h20, Branch = 1, Zero = 1, BrMode = 0, BrTarget = 8'hFC: next PC = 8'h1C. Repeat with Zero = 0: next PC = 8'h21.
- Absolute branch at PC = 8'hFF, BrMode = 1, BrTarget = 8'h05: next PC = 8'h05. Non-branch at 8'hFF: PC wraps to 8'h00.
- MemAccess = 1 with MemReady low for 3 cycles: Busy stays 1, PC and InstrCount hold, ExecEn = 0 for 3 cycles, then a single commit.
- Start asserted during WAIT: no commit and InstrCount = 0. Resume at Start_Addr.
- Counter saturation with CNT_W = 4: after 20 commits InstrCount = 4'hF. Reset_N low mid-run: all outputs return to 0 after one edge.
